// File: rtl/voice_alloc_pkg.sv
// Shared encodings for the voice allocator and its per-voice slots.
package voice_alloc_pkg;

  typedef enum logic [1:0] {
    VoiceFree,
    VoiceHeld,
    VoiceReleasing
  } voice_state_e;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StIssue,
    StStealOn
  } alloc_state_e;

  localparam int unsigned EvictW = 8;

endpackage

// File: rtl/voice_slot.sv
// One managed voice: lifecycle state, assigned note and saturating allocation age.
// Commands arrive from the allocator FSM; alloc_i wins over every other command.
module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int unsigned NoteW = 7,
  parameter int unsigned AgeW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  logic [NoteW-1:0] note_i,
  input  logic             release_i,
  input  logic             age_inc_i,
  input  logic             done_i,
  output voice_state_e     state_o,
  output logic [NoteW-1:0] note_o,
  output logic [AgeW-1:0]  age_o
);

  voice_state_e     state_q, state_d;
  logic [NoteW-1:0] note_q, note_d;
  logic [AgeW-1:0]  age_q, age_d;

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    age_d   = age_q;
    if (alloc_i) begin
      // Covers fresh allocation, retrigger and the second half of a steal.
      state_d = VoiceHeld;
      note_d  = note_i;
      age_d   = '0;
    end else if (release_i) begin
      if (state_q == VoiceHeld) begin
        state_d = VoiceReleasing;
      end
    end else if (done_i && (state_q == VoiceReleasing)) begin
      state_d = VoiceFree;
      age_d   = '0;
    end else if (age_inc_i && (state_q != VoiceFree) && (age_q != '1)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= VoiceFree;
      note_q  <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      age_q   <= age_d;
    end
  end

  assign state_o = state_q;
  assign note_o  = note_q;
  assign age_o   = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: serial scan of NUM_VOICES slots per note event.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping a note-on.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = 7,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [NUM_VOICES-1:0]        voice_done,
  output logic [NUM_VOICES-1:0]        voice_note_on,
  output logic [NUM_VOICES-1:0]        voice_note_off,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic [EvictW-1:0]            evict_cnt
);

  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VOICES - 1);
  localparam logic [NUM_VOICES-1:0] OneV = NUM_VOICES'(1);

  alloc_state_e state_q, state_d;

  logic              ev_on_q, ev_on_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic              found_free_q, found_free_d;
  logic [IdxW-1:0]   free_idx_q, free_idx_d;
  logic              found_match_q, found_match_d;
  logic [IdxW-1:0]   match_idx_q, match_idx_d;
  logic              found_old_q, found_old_d;
  logic [IdxW-1:0]   old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;

  logic [NUM_VOICES-1:0] note_on_q, note_on_d;
  logic [NUM_VOICES-1:0] note_off_q, note_off_d;
  logic [EvictW-1:0]     evict_q, evict_d;

  logic [NUM_VOICES-1:0] slot_alloc, slot_release, slot_age_inc;
  voice_state_e          slot_state [NUM_VOICES];
  logic [NOTE_W-1:0]     slot_note  [NUM_VOICES];
  logic [AGE_W-1:0]      slot_age   [NUM_VOICES];

  voice_state_e          scan_state;
  logic [NOTE_W-1:0]     scan_note;
  logic [AGE_W-1:0]      scan_age;
  logic [IdxW-1:0]       issue_idx;
  logic [NUM_VOICES-1:0] issue_oh;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .NoteW(NOTE_W),
      .AgeW (AGE_W)
    ) u_slot (
      .clk_i    (clk),
      .rst_ni   (rst_b),
      .alloc_i  (slot_alloc[i]),
      .note_i   (ev_note_q),
      .release_i(slot_release[i]),
      .age_inc_i(slot_age_inc[i]),
      .done_i   (voice_done[i]),
      .state_o  (slot_state[i]),
      .note_o   (slot_note[i]),
      .age_o    (slot_age[i])
    );
    assign voice_note[i*NOTE_W +: NOTE_W] = slot_note[i];
    assign voice_busy[i] = (slot_state[i] != VoiceFree);
  end

  assign scan_state = slot_state[idx_q];
  assign scan_note  = slot_note[idx_q];
  assign scan_age   = slot_age[idx_q];

  // A matching held voice is retriggered in preference to taking a free one.
  assign issue_idx = found_match_q ? match_idx_q : free_idx_q;
  assign issue_oh  = OneV << issue_idx;

`ifdef VOICE_STEAL_EN
  logic [NUM_VOICES-1:0] old_oh;
  assign old_oh = OneV << old_idx_q;
`else
  logic unused_old_idx;
  assign unused_old_idx = ^old_idx_q;
`endif

  always_comb begin
    state_d       = state_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    idx_d         = idx_q;
    found_free_d  = found_free_q;
    free_idx_d    = free_idx_q;
    found_match_d = found_match_q;
    match_idx_d   = match_idx_q;
    found_old_d   = found_old_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    note_on_d     = '0;
    note_off_d    = '0;
    evict_d       = evict_q;
    slot_alloc    = '0;
    slot_release  = '0;
    slot_age_inc  = '0;

    unique case (state_q)
      StIdle: begin
        if (ev_valid) begin
          ev_on_d       = ev_on;
          ev_note_d     = ev_note;
          idx_d         = '0;
          found_free_d  = 1'b0;
          found_match_d = 1'b0;
          found_old_d   = 1'b0;
          state_d       = StScan;
        end
      end

      StScan: begin
        if (!found_free_q && (scan_state == VoiceFree)) begin
          found_free_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (!found_match_q && (scan_state == VoiceHeld) && (scan_note == ev_note_q)) begin
          found_match_d = 1'b1;
          match_idx_d   = idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if ((scan_state != VoiceFree) && (!found_old_q || (scan_age > old_age_q))) begin
          found_old_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = scan_age;
        end
        if (idx_q == LastIdx) begin
          state_d = StIssue;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StIssue: begin
        state_d = StIdle;
        if (ev_on_q) begin
          if (found_match_q || found_free_q) begin
            note_on_d    = issue_oh;
            slot_alloc   = issue_oh;
            slot_age_inc = ~issue_oh;
          end else begin
            if (evict_q != '1) begin
              evict_d = evict_q + 1'b1;
            end
`ifdef VOICE_STEAL_EN
            // No free voice means every scanned voice was busy, so old_idx_q is valid.
            note_off_d = old_oh;
            state_d    = StStealOn;
`endif
          end
        end else if (found_match_q) begin
          note_off_d   = issue_oh;
          slot_release = issue_oh;
        end
      end

`ifdef VOICE_STEAL_EN
      StStealOn: begin
        note_on_d    = old_oh;
        slot_alloc   = old_oh;
        slot_age_inc = ~old_oh;
        state_d      = StIdle;
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= StIdle;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      idx_q         <= '0;
      found_free_q  <= 1'b0;
      free_idx_q    <= '0;
      found_match_q <= 1'b0;
      match_idx_q   <= '0;
      found_old_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      note_on_q     <= '0;
      note_off_q    <= '0;
      evict_q       <= '0;
    end else begin
      state_q       <= state_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      idx_q         <= idx_d;
      found_free_q  <= found_free_d;
      free_idx_q    <= free_idx_d;
      found_match_q <= found_match_d;
      match_idx_q   <= match_idx_d;
      found_old_q   <= found_old_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      note_on_q     <= note_on_d;
      note_off_q    <= note_off_d;
      evict_q       <= evict_d;
    end
  end

  assign ev_ready       = (state_q == StIdle);
  assign voice_note_on  = note_on_q;
  assign voice_note_off = note_off_q;
  assign evict_cnt      = evict_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator; the event-level model follows VOICE_STEAL_EN too.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int NW = 7;
  localparam int AW = 8;
  localparam int MFree = 0;
  localparam int MHeld = 1;
  localparam int MRel  = 2;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              ev_valid = 1'b0;
  logic              ev_ready;
  logic              ev_on = 1'b0;
  logic [NW-1:0]     ev_note = '0;
  logic [NV-1:0]     voice_done = '0;
  logic [NV-1:0]     voice_note_on;
  logic [NV-1:0]     voice_note_off;
  logic [NV*NW-1:0]  voice_note;
  logic [NV-1:0]     voice_busy;
  logic [7:0]        evict_cnt;

  voice_allocator #(
    .NUM_VOICES(NV),
    .NOTE_W    (NW),
    .AGE_W     (AW)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_on         (ev_on),
    .ev_note       (ev_note),
    .voice_done    (voice_done),
    .voice_note_on (voice_note_on),
    .voice_note_off(voice_note_off),
    .voice_note    (voice_note),
    .voice_busy    (voice_busy),
    .evict_cnt     (evict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [NV-1:0] on;
    logic [NV-1:0] off;
    int            vid;
    int            note;
    int            evict;
    logic [NV-1:0] busy;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  int m_st[NV];
  int m_note[NV];
  int m_age[NV];
  int m_evict;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_st[i] = MFree;
      m_note[i] = 0;
      m_age[i] = 0;
    end
    m_evict = 0;
  endtask

  task automatic model_alloc(input int k, input int note);
    for (int j = 0; j < NV; j++) begin
      if (j != k && m_st[j] != MFree && m_age[j] < 255) m_age[j]++;
    end
    m_st[k] = MHeld;
    m_note[k] = note;
    m_age[k] = 0;
  endtask

  task automatic push_rec(input int c, input int on_v, input int off_v, input int vid,
                          input int note);
    exp_t e;
    e.cyc = c;
    e.on = '0;
    e.off = '0;
    if (on_v >= 0) e.on[on_v] = 1'b1;
    if (off_v >= 0) e.off[off_v] = 1'b1;
    e.vid = vid;
    e.note = note;
    e.evict = m_evict;
    for (int i = 0; i < NV; i++) e.busy[i] = (m_st[i] != MFree);
    sb.push_back(e);
  endtask

  // Applies one accepted event; blen is how many cycles until the next accept is possible.
  task automatic model_event(input bit on, input int note, input int a, output int blen);
    int match = -1;
    int free_v = -1;
    int old = -1;
    blen = NV + 2;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && m_st[i] == MHeld && m_note[i] == note) match = i;
      if (free_v < 0 && m_st[i] == MFree) free_v = i;
      if (m_st[i] != MFree && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    if (on) begin
      if (match >= 0 || free_v >= 0) begin
        int k = (match >= 0) ? match : free_v;
        model_alloc(k, note);
        push_rec(a + NV + 1, k, -1, k, note);
      end else begin
        if (m_evict < 255) m_evict++;
`ifdef VOICE_STEAL_EN
        push_rec(a + NV + 1, -1, old, old, m_note[old]);
        model_alloc(old, note);
        push_rec(a + NV + 2, old, -1, old, note);
        blen = NV + 3;
`else
        push_rec(a + NV + 1, -1, -1, -1, 0);
`endif
      end
    end else if (match >= 0) begin
      m_st[match] = MRel;
      push_rec(a + NV + 1, -1, match, match, note);
    end else begin
      push_rec(a + NV + 1, -1, -1, -1, 0);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_b) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_issue: expected output at cycle %0d, now %0d", sb[0].cyc, cyc);
        sb.delete(0);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb[0];
        sb.delete(0);
        check("note_on", int'(voice_note_on), int'(e.on));
        check("note_off", int'(voice_note_off), int'(e.off));
        check("busy", int'(voice_busy), int'(e.busy));
        check("evict_cnt", int'(evict_cnt), e.evict);
        if (e.vid >= 0) check("voice_note", int'(voice_note[e.vid*NW +: NW]), e.note);
      end else if ((voice_note_on | voice_note_off) != '0) begin
        check("spurious_pulse", int'(voice_note_on | voice_note_off), 0);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!(ev_ready && sb.size() == 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!(ev_ready && sb.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: ready=%0d pending=%0d", ev_ready, sb.size());
      sb.delete();
    end
  endtask

  task automatic send(input bit on, input int note, input bit hold, output int acc,
                      output int blen);
    int t = 0;
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on = on;
    ev_note = NW'(note);
    while (!ev_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ev_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: ev_ready stayed 0, required 1");
      ev_valid = 1'b0;
      acc = -1;
      blen = 0;
    end else begin
      acc = cyc + 1;
      model_event(on, note, acc, blen);
      @(negedge clk);
      if (!hold) ev_valid = 1'b0;
    end
  endtask

  task automatic drive_done(input logic [NV-1:0] mask);
    wait_idle();
    voice_done = mask;
    @(negedge clk);
    voice_done = '0;
    for (int i = 0; i < NV; i++) begin
      if (mask[i] && m_st[i] == MRel) begin
        m_st[i] = MFree;
        m_age[i] = 0;
      end
    end
  endtask

  task automatic check_reset_vals();
    check("rst_ready", int'(ev_ready), 1);
    check("rst_busy", int'(voice_busy), 0);
    check("rst_pulses", int'(voice_note_on | voice_note_off), 0);
    check("rst_voice_note", int'(voice_note), 0);
    check("rst_evict", int'(evict_cnt), 0);
  endtask

  task automatic reset_dut();
    wait_idle();
    ev_valid = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    sb.delete();
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, bl, pa, pbl;
    int ev_tab_on[6] = '{1, 1, 0, 1, 1, 0};
    int ev_tab_note[6] = '{60, 62, 60, 60, 64, 99};

    model_reset();
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    check_reset_vals();

    // Single note-on lands on voice 0.
    send(1, 60, 0, a, bl);
    wait_idle();
    check("t1_note0", int'(voice_note[0 +: NW]), 60);
    check("t1_busy", int'(voice_busy), 1);

    // Release then done frees voice 1, which the next note-on reuses.
    reset_dut();
    send(1, 60, 0, a, bl);
    send(1, 62, 0, a, bl);
    send(1, 64, 0, a, bl);
    send(1, 65, 0, a, bl);
    send(0, 62, 0, a, bl);
    drive_done(4'b0010);
    check("t2_busy_after_done", int'(voice_busy), 'b1101);
    send(1, 67, 0, a, bl);
    wait_idle();
    check("t2_note1", int'(voice_note[NW +: NW]), 67);

    // Fifth note with all voices held: dropped, or steals voice 0.
    reset_dut();
    send(1, 60, 0, a, bl);
    send(1, 62, 0, a, bl);
    send(1, 64, 0, a, bl);
    send(1, 65, 0, a, bl);
    send(1, 67, 0, a, bl);
    wait_idle();
    check("t3_evict", int'(evict_cnt), 1);
`ifdef VOICE_STEAL_EN
    check("t3_note0", int'(voice_note[0 +: NW]), 67);
`else
    check("t3_note0", int'(voice_note[0 +: NW]), 60);
`endif

    // Unmatched off, then a retrigger of the same note.
    reset_dut();
    send(0, 70, 0, a, bl);
    send(1, 60, 0, a, bl);
    send(1, 60, 0, a, bl);
    wait_idle();
    check("t4_busy", int'(voice_busy), 1);

    // ev_valid held high across six events; each waits for ev_ready.
    reset_dut();
    pa = -1;
    pbl = 0;
    for (int k = 0; k < 6; k++) begin
      send(ev_tab_on[k][0], ev_tab_note[k], (k < 5), a, bl);
      if (pa >= 0) check("t5_accept_gap", a - pa, pbl);
      pa = a;
      pbl = bl;
    end
    wait_idle();

    // Reset while scanning aborts the event with no pulse.
    reset_dut();
    send(1, 60, 0, a, bl);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    sb.delete();
    model_reset();
    check_reset_vals();
    repeat (8) @(negedge clk);
    send(1, 60, 0, a, bl);
    wait_idle();
    check("t6_busy", int'(voice_busy), 1);

    // Random mix of events and done pulses.
    reset_dut();
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) < 2) begin
        drive_done(NV'($urandom_range(0, (1 << NV) - 1)));
      end else begin
        send(($urandom_range(0, 9) < 6), int'($urandom_range(60, 66)), 0, a, bl);
      end
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
